// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register bank: pointer-based writes and
// auto-incrementing reads, SDA driven open-drain through sda_oe only.
module i2c_target_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 16,
  localparam int        PW         = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          busy,
  output logic          addressed,
  output logic          wr_valid,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic          lcl_we,
  input  logic [PW-1:0] lcl_addr,
  input  logic [7:0]    lcl_wdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
  } state_t;

  logic          scl_m_q, scl_s_q, scl_d_q;
  logic          sda_m_q, sda_s_q, sda_d_q;
  state_t        state_q, state_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          rw_q, rw_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          addressed_q, addressed_d;
  logic          wr_valid_q, wr_valid_d;
  logic [PW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    bank_q [NUM_REGS];

  logic          scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0]    rx_byte, rd_byte;
  logic [PW-1:0] ptr_inc;

  assign scl_rise = scl_s_q & ~scl_d_q;
  assign scl_fall = ~scl_s_q & scl_d_q;
  assign start_ev = sda_d_q & ~sda_s_q & scl_s_q;
  assign stop_ev  = ~sda_d_q & sda_s_q & scl_s_q;
  assign rx_byte  = {shreg_q[6:0], sda_s_q};
  assign rd_byte  = bank_q[ptr_q];
  assign ptr_inc  = ptr_q + PW'(1);

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    rw_d        = rw_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    addressed_d = addressed_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (start_ev) begin
      state_d     = S_ADDR;
      bitcnt_d    = 4'd0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b1;
      addressed_d = 1'b0;
    end else if (stop_ev) begin
      state_d     = S_IDLE;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shreg_d  = rx_byte;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              if (state_q == S_ADDR) begin
                rw_d    = rx_byte[0];
                state_d = (rx_byte[7:1] == SLAVE_ADDR) ? S_ADDR_ACK : S_IGNORE;
              end else if (state_q == S_PTR) begin
                ptr_d   = rx_byte[PW-1:0];
                state_d = S_PTR_ACK;
              end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = rx_byte;
                ptr_d      = ptr_inc;
                state_d    = S_WDATA_ACK;
              end
            end
          end
        end
        // bitcnt 8: ACK not yet driven; bitcnt 9: ACK on the bus, next fall ends it
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (bitcnt_q == 4'd8) begin
              sda_oe_d = 1'b1;
              bitcnt_d = 4'd9;
            end else begin
              bitcnt_d = 4'd0;
              sda_oe_d = 1'b0;
              state_d  = S_WDATA;
              if (state_q == S_ADDR_ACK) begin
                addressed_d = 1'b1;
                if (rw_q) begin
                  shreg_d  = rd_byte;
                  sda_oe_d = ~rd_byte[7];
                  state_d  = S_RDATA;
                end else begin
                  state_d  = S_PTR;
                end
              end
            end
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            if (bitcnt_q == 4'd7) begin
              sda_oe_d = 1'b0;
              state_d  = S_RACK;
            end else begin
              shreg_d  = {shreg_q[6:0], 1'b0};
              sda_oe_d = ~shreg_q[6];
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end
        end
        // A fall in RACK can only follow an ACKed 9th rise; NACK leaves the state
        S_RACK: begin
          if (scl_rise) begin
            if (sda_s_q) begin
              addressed_d = 1'b0;
              state_d     = S_IGNORE;
            end else begin
              ptr_d = ptr_inc;
            end
          end else if (scl_fall) begin
            shreg_d  = rd_byte;
            sda_oe_d = ~rd_byte[7];
            bitcnt_d = 4'd0;
            state_d  = S_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_m_q     <= 1'b1;
      scl_s_q     <= 1'b1;
      scl_d_q     <= 1'b1;
      sda_m_q     <= 1'b1;
      sda_s_q     <= 1'b1;
      sda_d_q     <= 1'b1;
      state_q     <= S_IDLE;
      bitcnt_q    <= 4'd0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      scl_m_q     <= scl_i;
      scl_s_q     <= scl_m_q;
      scl_d_q     <= scl_s_q;
      sda_m_q     <= sda_i;
      sda_s_q     <= sda_m_q;
      sda_d_q     <= sda_s_q;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      addressed_q <= addressed_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
    shreg_q <= shreg_d;
    rw_q    <= rw_d;
  end

  // Bank commits the I2C byte while wr_valid is high; issued last so it wins a collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= 8'h00;
    end else begin
      if (lcl_we) bank_q[lcl_addr] <= lcl_wdata;
      if (wr_valid_q) bank_q[wr_addr_q] <= wr_data_q;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign addressed = addressed_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule
